// File: rtl/multicycle_control_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_control_fsm
//   Sequencing controller for the multicycle RV32I core. It walks each
//   instruction through FETCH / DECODE / EXECUTE / MEM / WB states, drives
//   the shared datapath selects and enables, owns the memory handshake, and
//   traps on an illegal opcode or a memory timeout.
//
// Parameters
//   MEM_TIMEOUT   max cycles a memory state waits for mem_ready before TRAP
//                 (0 = wait forever)
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   opcode[6:0]         instr[6:0] from the instruction register
//   branch_taken        ALU compare result for the current branch
//   mem_ready           memory completes the current request this cycle
//   mem_req, mem_write  memory request / store strobe
//   adr_src             0 = PC, 1 = ALU result register as address
//   pc_write, ir_write  PC and instruction/oldPC register enables
//   reg_write           register file write enable
//   result_src[1:0]     00 ALUOut, 01 mem data, 10 ALU result
//   alu_src_a[1:0]      00 PC, 01 oldPC, 10 rs1
//   alu_src_b[1:0]      00 rs2, 01 immediate, 10 constant 4
//   imm_src[2:0]        000 I, 001 S, 010 B, 011 J, 100 U
//   alu_op[2:0]         000 add, 001 branch compare, 010 funct, 011 pass B
//   halted              high while in TRAP
//   state_dbg[3:0]      current state encoding
// ---------------------------------------------------------------------------
module multicycle_control_fsm #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       branch_taken,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] imm_src,
    output logic       reg_write,
    output logic [2:0] alu_op,
    output logic       halted,
    output logic [3:0] state_dbg
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_EXECI    = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;
    localparam logic [3:0] S_JALR     = 4'd11;
    localparam logic [3:0] S_LUI      = 4'd12;
    localparam logic [3:0] S_LINK     = 4'd13;
    localparam logic [3:0] S_TRAP     = 4'd15;

    // Counter only ever needs to reach MEM_TIMEOUT-1.
    localparam int unsigned CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 32'd1);
    localparam logic TIMEOUT_EN = (MEM_TIMEOUT != 0);

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             in_mem_state;
    logic             mem_wait;
    logic             timed_out;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_FETCH;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign in_mem_state = (state_q == S_FETCH) || (state_q == S_MEMREAD) ||
                          (state_q == S_MEMWRITE);
    assign mem_wait     = in_mem_state && !mem_ready;
    // A ready in the final allowed cycle takes priority over the timeout.
    assign timed_out    = TIMEOUT_EN && mem_wait && (wait_cnt_q == CNT_LAST);

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FETCH:    if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                unique case (opcode)
                    7'b0000011,
                    7'b0100011: state_d = S_MEMADR;
                    7'b0110011: state_d = S_EXECR;
                    7'b0010011: state_d = S_EXECI;
                    7'b1100011: state_d = S_BRANCH;
                    7'b1101111: state_d = S_JAL;
                    7'b1100111: state_d = S_JALR;
                    7'b0110111: state_d = S_LUI;
                    default:    state_d = S_TRAP;
                endcase
            end
            S_MEMADR:   state_d = opcode[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_JALR:     state_d = S_LINK;
            S_LUI:      state_d = S_ALUWB;
            S_LINK:     state_d = S_FETCH;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_TRAP;
        endcase
        if (timed_out) state_d = S_TRAP;
    end

    // Wait counter: any state change clears it, which covers entry into
    // each memory state; it only advances while a memory state stalls.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_d != state_q) begin
            wait_cnt_d = '0;
        end else if (TIMEOUT_EN && mem_wait) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    // Output decode (combinational on state)
    always_comb begin
        mem_req    = 1'b0;
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        imm_src    = 3'b000;
        reg_write  = 1'b0;
        alu_op     = 3'b000;
        halted     = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                imm_src   = 3'b010;
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                imm_src   = opcode[5] ? 3'b001 : 3'b000;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req   = 1'b1;
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECR: begin
                alu_src_a = 2'b10;
                alu_op    = 3'b010;
            end
            S_EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 3'b010;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 2'b10;
                alu_op    = 3'b001;
                pc_write  = branch_taken;
            end
            S_JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
            end
            S_JALR: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                pc_write   = 1'b1;
            end
            S_LUI: begin
                alu_src_b = 2'b01;
                imm_src   = 3'b100;
                alu_op    = 3'b011;
            end
            S_LINK: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                reg_write  = 1'b1;
            end
            S_TRAP: begin
                halted = 1'b1;
            end
            default: begin
                halted = 1'b0;
            end
        endcase
    end

    assign state_dbg = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
module tb_multicycle_control_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] opcode;
    logic       branch_taken;
    logic       mem_ready;

    logic       mem_req, pc_write, adr_src, mem_write, ir_write, reg_write, halted;
    logic [1:0] result_src, alu_src_a, alu_src_b;
    logic [2:0] imm_src, alu_op;
    logic [3:0] state_dbg;

    logic       mem_req_4, pc_write_4, adr_src_4, mem_write_4, ir_write_4, reg_write_4, halted_4;
    logic [1:0] result_src_4, alu_src_a_4, alu_src_b_4;
    logic [2:0] imm_src_4, alu_op_4;
    logic [3:0] state_dbg_4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    multicycle_control_fsm dut (
        .clk(clk), .reset(reset), .opcode(opcode), .branch_taken(branch_taken),
        .mem_ready(mem_ready), .mem_req(mem_req), .pc_write(pc_write),
        .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
        .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .imm_src(imm_src), .reg_write(reg_write), .alu_op(alu_op),
        .halted(halted), .state_dbg(state_dbg)
    );

    multicycle_control_fsm #(.MEM_TIMEOUT(4)) dut4 (
        .clk(clk), .reset(reset), .opcode(opcode), .branch_taken(branch_taken),
        .mem_ready(mem_ready), .mem_req(mem_req_4), .pc_write(pc_write_4),
        .adr_src(adr_src_4), .mem_write(mem_write_4), .ir_write(ir_write_4),
        .result_src(result_src_4), .alu_src_a(alu_src_a_4), .alu_src_b(alu_src_b_4),
        .imm_src(imm_src_4), .reg_write(reg_write_4), .alu_op(alu_op_4),
        .halted(halted_4), .state_dbg(state_dbg_4)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; opcode = 7'b0; branch_taken = 1'b0; mem_ready = 1'b0;
        #3;
        total++;
        if (state_dbg !== 4'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state_dbg); end
        total++;
        if ({mem_req, alu_src_b} !== 3'b110) begin bad++; $display("FAIL reset_fetch_outs got=%b exp=110", {mem_req, alu_src_b}); end
        total++;
        if ({pc_write, ir_write, reg_write, mem_write, adr_src, halted, alu_src_a, imm_src, alu_op} !== 12'b0)
            begin bad++; $display("FAIL reset_zero_outs got=%b exp=0", {pc_write, ir_write, reg_write, mem_write, adr_src, halted, alu_src_a, imm_src, alu_op}); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_rtype();
        do_reset();
        opcode = 7'b0110011; mem_ready = 1'b1;
        #1;
        total++;
        if ({pc_write, ir_write, reg_write} !== 3'b110) begin bad++; $display("FAIL rtype_fetch_en got=%b exp=110", {pc_write, ir_write, reg_write}); end
        tick();
        total++;
        if ({state_dbg, pc_write, reg_write, alu_src_a, alu_src_b, imm_src} !== {4'd1, 1'b0, 1'b0, 2'b01, 2'b01, 3'b010})
            begin bad++; $display("FAIL rtype_decode got=%b", {state_dbg, pc_write, reg_write, alu_src_a, alu_src_b, imm_src}); end
        tick();
        total++;
        if ({state_dbg, pc_write, reg_write, alu_src_a, alu_src_b, alu_op} !== {4'd6, 1'b0, 1'b0, 2'b10, 2'b00, 3'b010})
            begin bad++; $display("FAIL rtype_execr got=%b", {state_dbg, pc_write, reg_write, alu_src_a, alu_src_b, alu_op}); end
        tick();
        total++;
        if ({state_dbg, pc_write, reg_write, result_src} !== {4'd8, 1'b0, 1'b1, 2'b00})
            begin bad++; $display("FAIL rtype_aluwb got=%b", {state_dbg, pc_write, reg_write, result_src}); end
        tick();
        total++;
        if (state_dbg !== 4'd0) begin bad++; $display("FAIL rtype_return got=%0d exp=0", state_dbg); end
    endtask

    task automatic test_load_wait();
        do_reset();
        opcode = 7'b0000011; mem_ready = 1'b1;
        tick(); tick();
        total++;
        if ({state_dbg, alu_src_a, alu_src_b, imm_src} !== {4'd2, 2'b10, 2'b01, 3'b000})
            begin bad++; $display("FAIL lw_memadr got=%b", {state_dbg, alu_src_a, alu_src_b, imm_src}); end
        mem_ready = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({state_dbg, mem_req, adr_src, mem_write} !== {4'd3, 3'b110})
                begin bad++; $display("FAIL lw_memread_hold%0d got=%b", i, {state_dbg, mem_req, adr_src, mem_write}); end
            tick();
        end
        mem_ready = 1'b1;
        total++;
        if (state_dbg !== 4'd3) begin bad++; $display("FAIL lw_memread_last got=%0d exp=3", state_dbg); end
        tick();
        total++;
        if ({state_dbg, result_src, reg_write} !== {4'd4, 2'b01, 1'b1})
            begin bad++; $display("FAIL lw_memwb got=%b", {state_dbg, result_src, reg_write}); end
        tick();
        total++;
        if (state_dbg !== 4'd0) begin bad++; $display("FAIL lw_return got=%0d exp=0", state_dbg); end
    endtask

    task automatic test_branch();
        for (int t = 0; t < 2; t++) begin
            do_reset();
            opcode = 7'b1100011; mem_ready = 1'b1; branch_taken = 1'b0;
            tick(); tick();
            branch_taken = (t == 1);
            #1;
            total++;
            if ({state_dbg, alu_op, pc_write} !== {4'd9, 3'b001, (t == 1)})
                begin bad++; $display("FAIL branch_t%0d got=%b", t, {state_dbg, alu_op, pc_write}); end
            tick();
            total++;
            if (state_dbg !== 4'd0) begin bad++; $display("FAIL branch_return%0d got=%0d exp=0", t, state_dbg); end
        end
        branch_taken = 1'b0;
    endtask

    task automatic test_paths();
        logic [6:0] ops [4] = '{7'b0010011, 7'b1101111, 7'b1100111, 7'b0110111};
        logic [5:0] exp [4][3] = '{
            '{{4'd1, 2'b00}, {4'd7,  2'b00}, {4'd8,  2'b01}},
            '{{4'd1, 2'b00}, {4'd10, 2'b10}, {4'd8,  2'b01}},
            '{{4'd1, 2'b00}, {4'd11, 2'b10}, {4'd13, 2'b01}},
            '{{4'd1, 2'b00}, {4'd12, 2'b00}, {4'd8,  2'b01}}};
        do_reset();
        mem_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            opcode = ops[k];
            for (int s = 0; s < 3; s++) begin
                tick();
                total++;
                if ({state_dbg, pc_write, reg_write} !== exp[k][s])
                    begin bad++; $display("FAIL path%0d_step%0d got=%b exp=%b", k, s, {state_dbg, pc_write, reg_write}, exp[k][s]); end
            end
            tick();
            total++;
            if (state_dbg !== 4'd0) begin bad++; $display("FAIL path%0d_return got=%0d exp=0", k, state_dbg); end
        end
    endtask

    task automatic test_trap();
        do_reset();
        opcode = 7'b1111111; mem_ready = 1'b1;
        tick();
        total++;
        if (state_dbg !== 4'd1) begin bad++; $display("FAIL trap_decode got=%0d exp=1", state_dbg); end
        for (int i = 0; i < 20; i++) begin
            tick();
            total++;
            if ({state_dbg, halted, pc_write, ir_write, reg_write, mem_req, mem_write} !== {4'd15, 6'b100000})
                begin bad++; $display("FAIL trap_hold%0d got=%b", i, {state_dbg, halted, pc_write, ir_write, reg_write, mem_req, mem_write}); end
        end
        mem_ready = 1'b0;
        do_reset();
        total++;
        if ({state_dbg, halted} !== {4'd0, 1'b0}) begin bad++; $display("FAIL trap_reset got=%b", {state_dbg, halted}); end
    endtask

    task automatic test_timeout();
        mem_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            total++;
            if (state_dbg_4 !== 4'd0) begin bad++; $display("FAIL timeout_fetch%0d got=%0d exp=0", i, state_dbg_4); end
            tick();
        end
        total++;
        if ({state_dbg_4, halted_4} !== {4'd15, 1'b1}) begin bad++; $display("FAIL timeout_trap got=%b exp=11111", {state_dbg_4, halted_4}); end
        total++;
        if (state_dbg !== 4'd0) begin bad++; $display("FAIL timeout_default_hold got=%0d exp=0", state_dbg); end
        do_reset();
        opcode = 7'b0110011;
        tick(); tick(); tick();
        mem_ready = 1'b1;
        tick();
        total++;
        if (state_dbg_4 !== 4'd1) begin bad++; $display("FAIL timeout_ready_wins got=%0d exp=1", state_dbg_4); end
    endtask

    task automatic test_reset_midstore();
        do_reset();
        opcode = 7'b0100011; mem_ready = 1'b1;
        tick();
        tick();
        total++;
        if ({state_dbg, imm_src} !== {4'd2, 3'b001}) begin bad++; $display("FAIL sw_memadr got=%b", {state_dbg, imm_src}); end
        mem_ready = 1'b0;
        tick();
        total++;
        if ({state_dbg, mem_req, adr_src, mem_write} !== {4'd5, 3'b111})
            begin bad++; $display("FAIL sw_memwrite got=%b", {state_dbg, mem_req, adr_src, mem_write}); end
        reset = 1'b1;
        #1;
        total++;
        if ({state_dbg, mem_write, pc_write, reg_write} !== {4'd0, 3'b000})
            begin bad++; $display("FAIL sw_async_reset got=%b", {state_dbg, mem_write, pc_write, reg_write}); end
        reset = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_load_wait();
        test_branch();
        test_paths();
        test_trap();
        test_timeout();
        test_reset_midstore();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
